// File: rtl/load_store_unit_if.sv
// Request/response bus between the execute stage and the load/store unit.
//   master : execute/writeback side (drives requests, accepts responses)
//   slave  : load/store unit
//   req_*  : one load/store request per valid/ready handshake
//   rsp_*  : load result with echoed destination tag, valid/ready handshake
//   misalign_err : one-cycle pulse for a word op at an odd byte address
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic              req_sext;
  logic [ADDR_W:0]   req_addr;
  logic [15:0]       req_wdata;
  logic [2:0]        req_dst;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_data;
  logic [2:0]        rsp_dst;
  logic              misalign_err;

  modport master (
    output req_valid, req_op, req_sext, req_addr, req_wdata, req_dst, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_dst, misalign_err
  );

  modport slave (
    input  req_valid, req_op, req_sext, req_addr, req_wdata, req_dst, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_dst, misalign_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a data memory with registered
// read/write ports. Word and byte accesses; byte stores are read-modify-write,
// byte loads are zero- or sign-extended.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   lsu                 request/response bus (slave side)
//   mem_wr/address_wr/din   memory write port (registered)
//   mem_rd/address_rd       memory read port (registered)
//   mem_dout            memory read data, valid the cycle after mem_rd is sampled
module load_store_unit #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  lsu,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address_wr,
  output logic [15:0]       mem_din,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_address_rd,
  input  logic [15:0]       mem_dout
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DST_W  = 3;

  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_SW = 2'b01;
  localparam logic [1:0] OP_LB = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_WAIT,
    S_LD_DATA,
    S_RMW_WAIT,
    S_RMW_DATA,
    S_RSP
  } state_t;

  state_t              state;
  logic                byte_q;
  logic                sext_q;
  logic                sel_q;
  logic [BYTE_W-1:0]   wbyte_q;
  logic [DST_W-1:0]    dst_q;

  logic                accept;
  logic                misalign;
  logic [ADDR_W-1:0]   word_addr;
  logic [BYTE_W-1:0]   ld_byte;
  logic [DATA_W-1:0]   ld_result;
  logic [DATA_W-1:0]   rmw_word;

  // Request decode
  assign accept    = lsu.req_valid & lsu.req_ready;
  assign word_addr = lsu.req_addr[ADDR_W:1];
  assign misalign  = ~lsu.req_op[1] & lsu.req_addr[0];

  // Load result formatting from the memory read data
  assign ld_byte   = sel_q ? mem_dout[15:8] : mem_dout[7:0];
  assign ld_result = byte_q ? {{BYTE_W{sext_q & ld_byte[BYTE_W-1]}}, ld_byte} : mem_dout;

  // Byte-store merge: replace the selected byte of the fetched word
  assign rmw_word  = sel_q ? {wbyte_q, mem_dout[7:0]} : {mem_dout[15:8], wbyte_q};

  // Control FSM with registered outputs; strobes default low every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      byte_q           <= 1'b0;
      sext_q           <= 1'b0;
      sel_q            <= 1'b0;
      wbyte_q          <= '0;
      dst_q            <= '0;
      lsu.req_ready    <= 1'b0;
      lsu.rsp_valid    <= 1'b0;
      lsu.rsp_data     <= '0;
      lsu.rsp_dst      <= '0;
      lsu.misalign_err <= 1'b0;
      mem_wr           <= 1'b0;
      mem_address_wr   <= '0;
      mem_din          <= '0;
      mem_rd           <= 1'b0;
      mem_address_rd   <= '0;
    end else begin
      mem_wr           <= 1'b0;
      mem_rd           <= 1'b0;
      lsu.misalign_err <= 1'b0;
      case (state)
        S_IDLE: begin
          lsu.req_ready <= 1'b1;
          if (accept) begin
            byte_q  <= lsu.req_op[1];
            sext_q  <= lsu.req_sext;
            sel_q   <= lsu.req_addr[0];
            wbyte_q <= lsu.req_wdata[BYTE_W-1:0];
            dst_q   <= lsu.req_dst;
            if (misalign) begin
              lsu.misalign_err <= 1'b1;
            end else begin
              case (lsu.req_op)
                OP_LW, OP_LB: begin
                  mem_rd         <= 1'b1;
                  mem_address_rd <= word_addr;
                  lsu.req_ready  <= 1'b0;
                  state          <= S_LD_WAIT;
                end
                OP_SW: begin
                  mem_wr         <= 1'b1;
                  mem_address_wr <= word_addr;
                  mem_din        <= lsu.req_wdata;
                end
                OP_SB: begin
                  mem_rd         <= 1'b1;
                  mem_address_rd <= word_addr;
                  // Write address is parked now; mem_wr stays low until the merge
                  mem_address_wr <= word_addr;
                  lsu.req_ready  <= 1'b0;
                  state          <= S_RMW_WAIT;
                end
              endcase
            end
          end
        end
        S_LD_WAIT: begin
          state <= S_LD_DATA;
        end
        S_LD_DATA: begin
          lsu.rsp_data  <= ld_result;
          lsu.rsp_dst   <= dst_q;
          lsu.rsp_valid <= 1'b1;
          state         <= S_RSP;
        end
        S_RSP: begin
          if (lsu.rsp_ready) begin
            lsu.rsp_valid <= 1'b0;
            lsu.req_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end
        S_RMW_WAIT: begin
          state <= S_RMW_DATA;
        end
        S_RMW_DATA: begin
          mem_din       <= rmw_word;
          mem_wr        <= 1'b1;
          lsu.req_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: begin
          lsu.req_ready <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by random traffic,
// checked against a word-array model of memory contents.
module tb_load_store_unit;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_address_wr;
  logic [15:0]       mem_din;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_address_rd;
  logic [15:0]       mem_dout;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu            (bus),
    .mem_wr         (mem_wr),
    .mem_address_wr (mem_address_wr),
    .mem_din        (mem_din),
    .mem_rd         (mem_rd),
    .mem_address_rd (mem_address_rd),
    .mem_dout       (mem_dout)
  );

  // Data memory with registered write and read ports
  logic [15:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_address_wr] <= mem_din;
    if (mem_rd) mem_dout <= mem[mem_address_rd];
  end

  // Reference contents of memory, updated per completed store
  logic [15:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_load(input logic [1:0] op, input logic sext, input logic [8:0] addr);
    int w;
    int b;
    w = int'(ref_mem[addr[8:1]]);
    if (op == 2'b00) return 16'(w);
    b = addr[0] ? w / 256 : w % 256;
    if (sext && b >= 128) b = b - 256;
    return 16'(b);
  endfunction

  function automatic logic [15:0] exp_merge(input logic [15:0] word, input logic sel, input logic [7:0] bval);
    int w;
    w = int'(word);
    if (sel) return 16'((w % 256) + int'(bval) * 256);
    return 16'((w / 256) * 256 + int'(bval));
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    while (bus.req_ready !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    check("req_ready_timeout", 32'(bus.req_ready), 32'h1);
  endtask

  // Issue one request, follow it through, check every visible effect
  task automatic do_op(input logic [1:0] op, input logic sext, input logic [8:0] addr,
                       input logic [15:0] wdata, input logic [2:0] dst, input int hold);
    logic [7:0]  wa;
    logic        sel;
    logic [15:0] exp;
    wa  = addr[8:1];
    sel = addr[0];
    wait_ready();
    bus.req_op    = op;
    bus.req_sext  = sext;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_dst   = dst;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    if (!op[1] && sel) begin
      check("misalign_pulse", 32'(bus.misalign_err), 32'h1);
      check("misalign_no_rd", 32'(mem_rd), 32'h0);
      check("misalign_no_wr", 32'(mem_wr), 32'h0);
      check("misalign_ready", 32'(bus.req_ready), 32'h1);
      step();
      check("misalign_end", 32'(bus.misalign_err), 32'h0);
      check("misalign_no_rsp", 32'(bus.rsp_valid), 32'h0);
      check("misalign_no_rd2", 32'(mem_rd | mem_wr), 32'h0);
    end else begin
      case (op)
        2'b01: begin
          check("sw_wr", 32'(mem_wr), 32'h1);
          check("sw_addr", 32'(mem_address_wr), 32'(wa));
          check("sw_din", 32'(mem_din), 32'(wdata));
          check("sw_no_rd", 32'(mem_rd), 32'h0);
          check("sw_ready", 32'(bus.req_ready), 32'h1);
          ref_mem[wa] = wdata;
        end
        2'b11: begin
          check("sb_rd", 32'(mem_rd), 32'h1);
          check("sb_rd_addr", 32'(mem_address_rd), 32'(wa));
          check("sb_no_wr", 32'(mem_wr), 32'h0);
          check("sb_busy1", 32'(bus.req_ready), 32'h0);
          step();
          check("sb_busy2", 32'(bus.req_ready), 32'h0);
          check("sb_idle_strobes", 32'(mem_rd | mem_wr), 32'h0);
          step();
          exp = exp_merge(ref_mem[wa], sel, wdata[7:0]);
          check("sb_wr", 32'(mem_wr), 32'h1);
          check("sb_wr_addr", 32'(mem_address_wr), 32'(wa));
          check("sb_din", 32'(mem_din), 32'(exp));
          check("sb_wr_no_rd", 32'(mem_rd), 32'h0);
          check("sb_ready", 32'(bus.req_ready), 32'h1);
          ref_mem[wa] = exp;
        end
        default: begin
          exp = exp_load(op, sext, addr);
          check("ld_rd", 32'(mem_rd), 32'h1);
          check("ld_rd_addr", 32'(mem_address_rd), 32'(wa));
          check("ld_no_wr", 32'(mem_wr), 32'h0);
          check("ld_busy", 32'(bus.req_ready), 32'h0);
          step();
          check("ld_rsp_early", 32'(bus.rsp_valid), 32'h0);
          check("ld_rd_once", 32'(mem_rd), 32'h0);
          step();
          check("ld_rsp_valid", 32'(bus.rsp_valid), 32'h1);
          check("ld_rsp_data", 32'(bus.rsp_data), 32'(exp));
          check("ld_rsp_dst", 32'(bus.rsp_dst), 32'(dst));
          for (int i = 0; i < hold; i++) begin
            step();
            check("ld_hold_valid", 32'(bus.rsp_valid), 32'h1);
            check("ld_hold_data", 32'(bus.rsp_data), 32'(exp));
            check("ld_hold_dst", 32'(bus.rsp_dst), 32'(dst));
            check("ld_hold_busy", 32'(bus.req_ready), 32'h0);
          end
          bus.rsp_ready = 1'b1;
          step();
          bus.rsp_ready = 1'b0;
          check("ld_rsp_done", 32'(bus.rsp_valid), 32'h0);
          check("ld_ready_after", 32'(bus.req_ready), 32'h1);
        end
      endcase
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_sext  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_dst   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    check("rst_misalign", 32'(bus.misalign_err), 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_mem_din", 32'(mem_din), 32'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(bus.req_ready), 32'h1);

    // Fill memory with back-to-back word stores, one per cycle
    bus.req_op = 2'b01;
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      bus.req_addr  = 9'(i * 2);
      bus.req_wdata = d;
      bus.req_valid = 1'b1;
      step();
      check("fill_wr", 32'(mem_wr), 32'h1);
      check("fill_addr", 32'(mem_address_wr), 32'(i));
      check("fill_din", 32'(mem_din), 32'(d));
      check("fill_ready", 32'(bus.req_ready), 32'h1);
      ref_mem[i] = d;
    end
    bus.req_valid = 1'b0;
    step();

    // Word store then load
    do_op(2'b01, 1'b0, 9'h010, 16'h1234, 3'd0, 0);
    do_op(2'b00, 1'b0, 9'h010, 16'h0000, 3'd5, 0);

    // Byte stores by read-modify-write
    do_op(2'b01, 1'b0, 9'h010, 16'hABCD, 3'd0, 0);
    do_op(2'b11, 1'b0, 9'h011, 16'h005A, 3'd0, 0);
    do_op(2'b00, 1'b0, 9'h010, 16'h0000, 3'd1, 0);
    check("rmw_hi_literal", 32'(ref_mem[8]), 32'h5ACD);
    do_op(2'b11, 1'b0, 9'h010, 16'h0077, 3'd0, 0);
    do_op(2'b00, 1'b0, 9'h010, 16'h0000, 3'd2, 0);

    // Byte loads with extension
    do_op(2'b01, 1'b0, 9'h010, 16'h80F0, 3'd0, 0);
    do_op(2'b10, 1'b1, 9'h010, 16'h0000, 3'd3, 0);
    do_op(2'b10, 1'b0, 9'h011, 16'h0000, 3'd4, 0);
    do_op(2'b10, 1'b1, 9'h011, 16'h0000, 3'd6, 0);

    // Response back-pressure, then an immediate follow-on request
    do_op(2'b00, 1'b0, 9'h010, 16'h0000, 3'd7, 5);
    do_op(2'b00, 1'b0, 9'h020, 16'h0000, 3'd2, 0);

    // Misaligned word load and store
    do_op(2'b00, 1'b0, 9'h021, 16'h0000, 3'd1, 0);
    do_op(2'b01, 1'b0, 9'h021, 16'hDEAD, 3'd1, 0);

    // Address wrap at the top of memory
    do_op(2'b11, 1'b0, 9'h1FF, 16'h00C3, 3'd0, 0);
    do_op(2'b10, 1'b1, 9'h1FF, 16'h0000, 3'd5, 0);

    // Reset during the RMW merge cycle drops the write
    wait_ready();
    bus.req_op    = 2'b11;
    bus.req_addr  = 9'h010;
    bus.req_wdata = 16'h0099;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rst_rmw_wr", 32'(mem_wr), 32'h0);
    check("rst_rmw_ready", 32'(bus.req_ready), 32'h0);
    step();
    step();
    check("rst_rmw_wr_held", 32'(mem_wr), 32'h0);
    rst_n = 1'b1;
    step();
    check("rst_rmw_ready_after", 32'(bus.req_ready), 32'h1);
    do_op(2'b00, 1'b0, 9'h010, 16'h0000, 3'd3, 0);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      do_op(2'($urandom_range(0, 3)), 1'($urandom), 9'($urandom), 16'($urandom),
            3'($urandom), int'($urandom_range(0, 3)));
    end
    step();
    step();

    // Final memory image
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
